// File: rtl/blake3_hash_check.sv
// BLAKE3 output-hash check: h[i] = V[i]^V[i+8], compared against a big-endian target in 3 stages, hits queued in a FIFO.
// Optional saturating checked/hit counters are compiled in with BLAKE3_CHECK_STATS_EN.
module blake3_hash_check #(
    parameter int NONCE_W        = 64,
    parameter int HIT_FIFO_DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Rst_n_I,
    input  logic               Valid_I,
    input  logic [511:0]       V_I,
    input  logic [NONCE_W-1:0] Nonce_I,
    input  logic [255:0]       Target_I,
    output logic               Hit_Valid_O,
    input  logic               Hit_Ready_I,
    output logic [NONCE_W-1:0] Hit_Nonce_O,
    output logic [255:0]       Hit_Hash_O,
    output logic               Overflow_O
`ifdef BLAKE3_CHECK_STATS_EN
    ,
    output logic [47:0]        Checked_Cnt_O,
    output logic [31:0]        Hit_Cnt_O
`endif
);
    localparam int AW = $clog2(HIT_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [255:0]       h_in;
    logic               s1_valid;
    logic [255:0]       s1_hash;
    logic [NONCE_W-1:0] s1_nonce;
    logic [255:0]       s1_target;
    logic [255:0]       s1_int;
    logic               s2_valid;
    logic [255:0]       s2_hash;
    logic [NONCE_W-1:0] s2_nonce;
    logic [3:0]         s2_lt;
    logic [3:0]         s2_eq;
    logic               s2_le;
    logic               s3_hit;
    logic [255:0]       s3_hash;
    logic [NONCE_W-1:0] s3_nonce;

    always_comb begin
        h_in   = '0;
        s1_int = '0;
        for (int i = 0; i < 8; i++) begin
            h_in[32*i +: 32]        = V_I[32*i +: 32] ^ V_I[32*(i+8) +: 32];
            // BLAKE3 byte stream is little-endian per word; h[0] is the most significant word of H
            s1_int[255-32*i -: 32]  = bswap32(s1_hash[32*i +: 32]);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n_I) begin
        if (!Rst_n_I) begin
            s1_valid  <= 1'b0;
            s1_hash   <= '0;
            s1_nonce  <= '0;
            s1_target <= '0;
        end else begin
            s1_valid <= Valid_I;
            if (Valid_I) begin
                s1_hash   <= h_in;
                s1_nonce  <= Nonce_I;
                s1_target <= Target_I;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n_I) begin
        if (!Rst_n_I) begin
            s2_valid <= 1'b0;
            s2_hash  <= '0;
            s2_nonce <= '0;
            s2_lt    <= '0;
            s2_eq    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_hash  <= s1_hash;
            s2_nonce <= s1_nonce;
            for (int k = 0; k < 4; k++) begin
                s2_lt[k] <= s1_int[255-64*k -: 64] <  s1_target[255-64*k -: 64];
                s2_eq[k] <= s1_int[255-64*k -: 64] == s1_target[255-64*k -: 64];
            end
        end
    end

    // Lane 0 is most significant; equality falls through to the next lane, full equality is a hit.
    assign s2_le = s2_lt[0] | (s2_eq[0] & (s2_lt[1] | (s2_eq[1] &
                   (s2_lt[2] | (s2_eq[2] & (s2_lt[3] | s2_eq[3]))))));

    always_ff @(posedge Clk or negedge Rst_n_I) begin
        if (!Rst_n_I) begin
            s3_hit   <= 1'b0;
            s3_hash  <= '0;
            s3_nonce <= '0;
        end else begin
            s3_hit   <= s2_valid & s2_le;
            s3_hash  <= s2_hash;
            s3_nonce <= s2_nonce;
        end
    end

    // Hit handshake: an entry transfers on a rising edge where Hit_Valid_O and Hit_Ready_I are both 1;
    // Hit_Valid_O never depends on Hit_Ready_I and the head stays stable until it transfers.
    logic [NONCE_W-1:0] mem_nonce [HIT_FIFO_DEPTH];
    logic [255:0]       mem_hash  [HIT_FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [NONCE_W-1:0] last_nonce;
    logic [255:0]       last_hash;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop         = !empty && Hit_Ready_I;
    assign push        = s3_hit && (!full || pop);
    assign Hit_Valid_O = !empty;
    assign Hit_Nonce_O = empty ? last_nonce : mem_nonce[rd_ptr[AW-1:0]];
    assign Hit_Hash_O  = empty ? last_hash  : mem_hash[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_nonce[wr_ptr[AW-1:0]] <= s3_nonce;
            mem_hash[wr_ptr[AW-1:0]]  <= s3_hash;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n_I) begin
        if (!Rst_n_I) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_nonce <= '0;
            last_hash  <= '0;
            Overflow_O <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                last_nonce <= mem_nonce[rd_ptr[AW-1:0]];
                last_hash  <= mem_hash[rd_ptr[AW-1:0]];
            end
            if (s3_hit && full && !pop) Overflow_O <= 1'b1;
        end
    end

`ifdef BLAKE3_CHECK_STATS_EN
    logic s3_valid;

    always_ff @(posedge Clk or negedge Rst_n_I) begin
        if (!Rst_n_I) begin
            s3_valid      <= 1'b0;
            Checked_Cnt_O <= '0;
            Hit_Cnt_O     <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s3_valid && (Checked_Cnt_O != '1)) Checked_Cnt_O <= Checked_Cnt_O + 48'd1;
            if (s3_hit && (Hit_Cnt_O != '1))       Hit_Cnt_O     <= Hit_Cnt_O + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_blake3_hash_check.sv
// Directed bench for blake3_hash_check: latency, compare boundaries, lane priority, streaming, overflow, reset.
// Counter checks are included when BLAKE3_CHECK_STATS_EN is defined.
module tb_blake3_hash_check;
    localparam int NONCE_W = 64;

    logic               Clk = 1'b0;
    logic               Rst_n_I = 1'b0;
    logic               Valid_I = 1'b0;
    logic [511:0]       V_I = '0;
    logic [NONCE_W-1:0] Nonce_I = '0;
    logic [255:0]       Target_I = '0;
    logic               Hit_Valid_O;
    logic               Hit_Ready_I = 1'b0;
    logic [NONCE_W-1:0] Hit_Nonce_O;
    logic [255:0]       Hit_Hash_O;
    logic               Overflow_O;
`ifdef BLAKE3_CHECK_STATS_EN
    logic [47:0]        Checked_Cnt_O;
    logic [31:0]        Hit_Cnt_O;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [NONCE_W+255:0] exp_q[$];

    blake3_hash_check #(.NONCE_W(NONCE_W), .HIT_FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Rst_n_I(Rst_n_I), .Valid_I(Valid_I), .V_I(V_I), .Nonce_I(Nonce_I),
        .Target_I(Target_I), .Hit_Valid_O(Hit_Valid_O), .Hit_Ready_I(Hit_Ready_I),
        .Hit_Nonce_O(Hit_Nonce_O), .Hit_Hash_O(Hit_Hash_O), .Overflow_O(Overflow_O)
`ifdef BLAKE3_CHECK_STATS_EN
        , .Checked_Cnt_O(Checked_Cnt_O), .Hit_Cnt_O(Hit_Cnt_O)
`endif
    );

    always #5 Clk = ~Clk;

    localparam logic [255:0] H_EIGHTS = {8{32'h08000000}};
    localparam logic [255:0] HASH_EIGHTS = {8{32'h00000008}};

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rst_n_I = 1'b0;
        Valid_I = 1'b0;
        Hit_Ready_I = 1'b0;
        step();
        step();
        Rst_n_I = 1'b1;
        step();
    endtask

    task automatic drive_cand(input logic [511:0] v, input logic [NONCE_W-1:0] n);
        Valid_I = 1'b1;
        V_I = v;
        Nonce_I = n;
    endtask

    function automatic logic [511:0] v_index();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = 32'(i);
        return v;
    endfunction

    function automatic logic [255:0] hash_of(input logic [511:0] v);
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = v[32*i +: 32] ^ v[256+32*i +: 32];
        return h;
    endfunction

    task automatic test_reset();
        apply_reset();
        vectors += 4;
        if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", Hit_Valid_O); end
        if (Hit_Nonce_O !== '0) begin miscompares++; $display("FAIL reset_nonce got %h want 0", Hit_Nonce_O); end
        if (Hit_Hash_O !== '0) begin miscompares++; $display("FAIL reset_hash got %h want 0", Hit_Hash_O); end
        if (Overflow_O !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", Overflow_O); end
    endtask

    task automatic test_equal();
        apply_reset();
        Target_I = H_EIGHTS;
        drive_cand(v_index(), 64'h1234);
        step();
        Valid_I = 1'b0;
        step();
        step();
        vectors++;
        if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL equal_early got %b want 0", Hit_Valid_O); end
        step();
        vectors += 3;
        if (Hit_Valid_O !== 1'b1) begin miscompares++; $display("FAIL equal_valid got %b want 1", Hit_Valid_O); end
        if (Hit_Nonce_O !== 64'h1234) begin miscompares++; $display("FAIL equal_nonce got %h want 1234", Hit_Nonce_O); end
        if (Hit_Hash_O !== HASH_EIGHTS) begin miscompares++; $display("FAIL equal_hash got %h want %h", Hit_Hash_O, HASH_EIGHTS); end
        Hit_Ready_I = 1'b1;
        step();
        Hit_Ready_I = 1'b0;
        vectors += 3;
        if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL equal_pop got %b want 0", Hit_Valid_O); end
        if (Hit_Hash_O !== HASH_EIGHTS) begin miscompares++; $display("FAIL equal_hold_hash got %h want %h", Hit_Hash_O, HASH_EIGHTS); end
        if (Hit_Nonce_O !== 64'h1234) begin miscompares++; $display("FAIL equal_hold_nonce got %h want 1234", Hit_Nonce_O); end
    endtask

    task automatic test_above();
        apply_reset();
        Target_I = {{7{32'h08000000}}, 32'h07FFFFFF};
        drive_cand(v_index(), 64'h55);
        step();
        Valid_I = 1'b0;
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL above_nohit cycle %0d got %b want 0", c, Hit_Valid_O); end
            step();
        end
`ifdef BLAKE3_CHECK_STATS_EN
        vectors += 2;
        if (Checked_Cnt_O !== 48'd1) begin miscompares++; $display("FAIL above_checked got %0d want 1", Checked_Cnt_O); end
        if (Hit_Cnt_O !== 32'd0) begin miscompares++; $display("FAIL above_hitcnt got %0d want 0", Hit_Cnt_O); end
`endif
    endtask

    task automatic test_lane_priority();
        logic [255:0] h1;
        logic [255:0] h2;
        h1 = {32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h05000000, 32'h0};
        h2 = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h20000000, 32'h0};
        apply_reset();
        Target_I = {64'h10, 64'h0, 64'h0, 64'h0};
        drive_cand({256'h0, h1}, 64'd1);
        step();
        Target_I = {64'h10, {192{1'b1}}};
        drive_cand({256'h0, h2}, 64'd2);
        step();
        Valid_I = 1'b0;
        step();
        step();
        vectors += 3;
        if (Hit_Valid_O !== 1'b1) begin miscompares++; $display("FAIL lane_hit_valid got %b want 1", Hit_Valid_O); end
        if (Hit_Nonce_O !== 64'd1) begin miscompares++; $display("FAIL lane_hit_nonce got %h want 1", Hit_Nonce_O); end
        if (Hit_Hash_O !== h1) begin miscompares++; $display("FAIL lane_hit_hash got %h want %h", Hit_Hash_O, h1); end
        step();
        vectors++;
        if (Hit_Nonce_O !== 64'd1) begin miscompares++; $display("FAIL lane_head_hold got %h want 1", Hit_Nonce_O); end
        Hit_Ready_I = 1'b1;
        step();
        Hit_Ready_I = 1'b0;
        vectors++;
        if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL lane_nohit got %b want 0", Hit_Valid_O); end
`ifdef BLAKE3_CHECK_STATS_EN
        vectors += 2;
        if (Checked_Cnt_O !== 48'd2) begin miscompares++; $display("FAIL lane_checked got %0d want 2", Checked_Cnt_O); end
        if (Hit_Cnt_O !== 32'd1) begin miscompares++; $display("FAIL lane_hitcnt got %0d want 1", Hit_Cnt_O); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [511:0] v;
        logic [NONCE_W+255:0] exp;
        int hits;
        hits = 0;
        apply_reset();
        exp_q.delete();
        Target_I = '1;
        Hit_Ready_I = 1'b1;
        for (int c = 0; c < 112; c++) begin
            if (Hit_Valid_O) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra got nonce %h want none", Hit_Nonce_O);
                end else begin
                    exp = exp_q.pop_front();
                    hits++;
                    if ({Hit_Nonce_O, Hit_Hash_O} !== exp) begin
                        miscompares++;
                        $display("FAIL stream_entry got %h/%h want %h/%h", Hit_Nonce_O, Hit_Hash_O,
                                 exp[NONCE_W+255:256], exp[255:0]);
                    end
                end
            end
            if (c < 100) begin
                for (int w = 0; w < 16; w++) v[32*w +: 32] = $urandom;
                drive_cand(v, 64'h100 + 64'(c));
                exp_q.push_back({64'h100 + 64'(c), hash_of(v)});
            end else begin
                Valid_I = 1'b0;
            end
            step();
        end
        Hit_Ready_I = 1'b0;
        vectors += 2;
        if (hits !== 100) begin miscompares++; $display("FAIL stream_count got %0d want 100", hits); end
        if (Overflow_O !== 1'b0) begin miscompares++; $display("FAIL stream_overflow got %b want 0", Overflow_O); end
`ifdef BLAKE3_CHECK_STATS_EN
        vectors += 2;
        if (Checked_Cnt_O !== 48'd100) begin miscompares++; $display("FAIL stream_checked got %0d want 100", Checked_Cnt_O); end
        if (Hit_Cnt_O !== 32'd100) begin miscompares++; $display("FAIL stream_hitcnt got %0d want 100", Hit_Cnt_O); end
`endif
    endtask

    task automatic test_overflow();
        apply_reset();
        Target_I = '1;
        for (int c = 0; c < 6; c++) begin
            drive_cand(v_index(), 64'(c));
            step();
        end
        Valid_I = 1'b0;
        for (int c = 0; c < 5; c++) step();
        vectors += 3;
        if (Overflow_O !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", Overflow_O); end
        if (Hit_Valid_O !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got %b want 1", Hit_Valid_O); end
        if (Hit_Hash_O !== HASH_EIGHTS) begin miscompares++; $display("FAIL ovf_hash got %h want %h", Hit_Hash_O, HASH_EIGHTS); end
        Hit_Ready_I = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (Hit_Valid_O !== 1'b1 || Hit_Nonce_O !== 64'(k)) begin
                miscompares++;
                $display("FAIL ovf_drain valid %b nonce %h want 1/%h", Hit_Valid_O, Hit_Nonce_O, 64'(k));
            end
            step();
        end
        Hit_Ready_I = 1'b0;
        vectors += 2;
        if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %b want 0", Hit_Valid_O); end
        if (Overflow_O !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", Overflow_O); end
`ifdef BLAKE3_CHECK_STATS_EN
        vectors++;
        if (Hit_Cnt_O !== 32'd6) begin miscompares++; $display("FAIL ovf_hitcnt got %0d want 6", Hit_Cnt_O); end
`endif
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        Target_I = '1;
        for (int c = 0; c < 5; c++) begin
            drive_cand(v_index(), 64'(10 + c));
            step();
        end
        Valid_I = 1'b0;
        step();
        step();
        vectors++;
        if (Hit_Nonce_O !== 64'd10) begin miscompares++; $display("FAIL fpp_head got %h want a", Hit_Nonce_O); end
        Hit_Ready_I = 1'b1;
        step();
        Hit_Ready_I = 1'b0;
        vectors++;
        if (Overflow_O !== 1'b0) begin miscompares++; $display("FAIL fpp_overflow got %b want 0", Overflow_O); end
        Hit_Ready_I = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (Hit_Valid_O !== 1'b1 || Hit_Nonce_O !== 64'(11 + k)) begin
                miscompares++;
                $display("FAIL fpp_drain valid %b nonce %h want 1/%h", Hit_Valid_O, Hit_Nonce_O, 64'(11 + k));
            end
            step();
        end
        Hit_Ready_I = 1'b0;
        vectors++;
        if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL fpp_empty got %b want 0", Hit_Valid_O); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        Target_I = '1;
        for (int c = 0; c < 8; c++) begin
            drive_cand(v_index(), 64'(20 + c));
            step();
        end
        vectors += 2;
        if (Overflow_O !== 1'b1) begin miscompares++; $display("FAIL mid_pre_overflow got %b want 1", Overflow_O); end
        if (Hit_Valid_O !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got %b want 1", Hit_Valid_O); end
        Rst_n_I = 1'b0;
        #1;
        vectors += 3;
        if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", Hit_Valid_O); end
        if (Overflow_O !== 1'b0) begin miscompares++; $display("FAIL mid_rst_overflow got %b want 0", Overflow_O); end
        if (Hit_Nonce_O !== '0) begin miscompares++; $display("FAIL mid_rst_nonce got %h want 0", Hit_Nonce_O); end
        step();
        Valid_I = 1'b0;
        step();
        Rst_n_I = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++;
            if (Hit_Valid_O !== 1'b0) begin miscompares++; $display("FAIL mid_flushed cycle %0d got %b want 0", c, Hit_Valid_O); end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_above();
        test_lane_priority();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/blake3_hash_check.md
Name: blake3_hash_check

Overview:
- Pipelined stage directly downstream of the final G_round of the BLAKE3 compression pipeline.
- Consumes the 16-word state V, computes the 256-bit output hash h[i] = V[i] ^ V[i+8] (i=0..7), and compares it against a target.
- Winning nonces, with their hashes, are pushed into a small hit FIFO.
- The FIFO is drained by the job controller through a valid/ready handshake.
- Full throughput: one candidate per clock, no backpressure to the round pipeline.

Parameters:
- NONCE_W, 64, width of the nonce tag that travels with each candidate.
- HIT_FIFO_DEPTH, 4, hit FIFO entries; power of two, minimum 2.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst_n_I  in  1  asynchronous, active-low reset.
- Valid_I  in  1  V_I/Nonce_I carry a candidate this cycle.
- V_I  in  512  final state; word i at bits [32i+31:32i].
- Nonce_I  in  NONCE_W  nonce tag aligned with V_I.
- Target_I  in  256  big-endian integer target; quasi-static.
- Hit_Valid_O  out  1  FIFO head is valid.
- Hit_Ready_I  in  1  consumer accepts the FIFO head.
- Hit_Nonce_O  out  NONCE_W  nonce of the FIFO head.
- Hit_Hash_O  out  256  hash of the FIFO head; h[i] at bits [32i+31:32i].
- Overflow_O  out  1  sticky; a hit was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All stage valids 0, FIFO empty, Overflow_O 0.
  - Hit_Valid_O 0, Hit_Nonce_O 0, Hit_Hash_O 0.
  - Reset mid-operation discards in-flight candidates and stored hits.
- Stage 1 (S1):
  - On Valid_I, register h[0..7] = V_I[i] ^ V_I[i+8], Nonce_I and Target_I.
  - Data registers load only when Valid_I is 1; the valid bit always loads.
- Integer form of the hash:
  - H = concatenation of byteswap(h[0]) .. byteswap(h[7]), with h[0] in the most significant position.
  - This matches the BLAKE3 little-endian byte stream read as a big-endian integer.
- Stage 2 (S2):
  - Split H and the target into four 64-bit lanes.
  - Register per lane: lt[k] = H_lane < T_lane, eq[k] = H_lane == T_lane.
  - Carry h, nonce and valid forward.
- Stage 3 (S3):
  - hit = valid & (H <= Target), resolved most-significant lane first from lt/eq.
  - Registered; Hit_Valid_O can rise earliest on the cycle after S3, i.e. 4 clocks after Valid_I.
- Total latency: Valid_I to FIFO push = 3 clocks, fixed, independent of data.
- Hit FIFO:
  - Circular buffer with read/write pointers of log2(HIT_FIFO_DEPTH)+1 bits; full/empty derived from the wrap bit.
  - Push when S3 hit and not full.
  - Pop when Hit_Valid_O & Hit_Ready_I.
  - Push and pop in the same cycle are both performed, including when full (no drop) and when holding one entry.
  - Outputs are driven from registered head data (read from the array at the read pointer). When empty, Hit_Valid_O = 0 and the data outputs hold their last value.
  - Hit_Ready_I while empty has no effect.
- Overflow:
  - Condition: S3 hit while full and no pop this cycle.
  - Action: the hit is dropped and Overflow_O is set; it clears only on reset.
- Target_I changes take effect for candidates entering S1 on or after the change. In-flight candidates use their captured target.
- Equal hash and target counts as a hit. A target of all-ones makes every valid candidate a hit.

Optional Feature:
- Macro: BLAKE3_CHECK_STATS_EN.
- When defined, add output ports:
  - Checked_Cnt_O (48 bit): increments once per S3 valid.
  - Hit_Cnt_O (32 bit): increments per S3 hit, including dropped hits.
  - Both saturate at all-ones and reset to 0.
- When undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Equal to target: V_I word i = i (i=0..15) → h[i] = 8 for all i. Set Target_I = H. Valid_I for 1 cycle with Nonce_I = 0x1234 → Hit_Valid_O rises 4 clocks later with Hit_Nonce_O = 0x1234 and every Hit_Hash_O word = 0x00000008.
- Above target: same V_I, Target_I = H−1 (lane 3 differs by 1 only) → no hit, FIFO stays empty. With BLAKE3_CHECK_STATS_EN: Checked_Cnt_O = 1, Hit_Cnt_O = 0.
- Lane priority: H lane0 (MS) smaller than target lane0, lane1 larger → hit. H lane0 larger, all other lanes smaller → no hit.
- Streaming and ordering: 100 back-to-back candidates, Target_I all-ones, Hit_Ready_I = 1 constantly → 100 hits in nonce order, no Overflow_O.
- Overflow: Hit_Ready_I = 0 and 6 consecutive hits with DEPTH 4 → 4 stored (nonces 0..3), Overflow_O = 1. Then raise Hit_Ready_I → nonces 0,1,2,3 pop in order.
- Reset and full-FIFO push/pop: assert Rst_n_I low mid-stream → Hit_Valid_O and Overflow_O go to 0 immediately. With the FIFO full, a push and pop in the same cycle → count stays 4 and Overflow_O stays 0.
